// File: rtl/buffer_reg_arbiter.sv
// rtl/buffer_reg_arbiter.sv - round-robin arbiter sharing one buffer register between requesters
// Optional feature macro: BUFREG_ARB_TIMEOUT_EN (drop an unconsumed word after TIMEOUT cycles in FULL)
module buffer_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_owner,
  input  logic                       out_ready,
  output logic                       drop_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [NUM_REQ-1:0] r_req_ready;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [IDX_W-1:0]   r_out_owner;

  logic               w_found;
  logic [IDX_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_sel_valid;
  logic [DATA_W-1:0]  w_sel_data;

`ifdef BUFREG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   r_cnt;
  logic               r_drop_pulse;
`endif

  // Round-robin search: first requesting index at or above rr_ptr, wrapping around
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_l;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    idx_l    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_l = IDX_W'(idx);
      if (!w_found && req_valid[idx_l]) begin
        w_found  = 1'b1;
        w_winner = idx_l;
      end
    end
  end

  // One-hot form of the winner, loaded into the registered grant strobe
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_onehot[i] = w_found && (IDX_W'(i) == w_winner);
    end
  end

  // Select the granted requester's valid and data for the LOAD capture
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == r_grant_idx) begin
        w_sel_valid = req_valid[i];
        w_sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Sequencer: arbitrate in IDLE, capture in LOAD, hold the word in FULL until consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_grant_idx  <= '0;
      r_req_ready  <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_owner  <= '0;
`ifdef BUFREG_ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_drop_pulse <= 1'b0;
`endif
    end else begin
`ifdef BUFREG_ARB_TIMEOUT_EN
      r_drop_pulse <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_idx <= w_winner;
            r_req_ready <= w_onehot;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_req_ready <= '0;
          if (w_sel_valid) begin
            r_out_data  <= w_sel_data;
            r_out_owner <= r_grant_idx;
            r_out_valid <= 1'b1;
            r_rr_ptr    <= (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;
`ifdef BUFREG_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
            r_state     <= ST_FULL;
          end else begin
            // Requester withdrew: nothing captured, pointer kept so it stays first in line
            r_state     <= ST_IDLE;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
`ifdef BUFREG_ARB_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 1'b1;
            // This cycle brings the count to TIMEOUT: discard the word
            if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
              r_out_valid  <= 1'b0;
              r_drop_pulse <= 1'b1;
              r_state      <= ST_IDLE;
            end
          end
`endif
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= '0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_owner = r_out_owner;
`ifdef BUFREG_ARB_TIMEOUT_EN
  assign drop_pulse = r_drop_pulse;
`else
  assign drop_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_reg_arbiter.sv
// tb/tb_buffer_reg_arbiter.sv - randomized and directed bench for buffer_reg_arbiter against a behavioural model
module tb_buffer_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 8;

  logic               clk;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_data;
  logic [N-1:0]       req_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic [$clog2(N)-1:0] out_owner;
  logic               out_ready;
  logic               drop_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: which requester holds a grant (-1 none), whether a word is held, and the word
  int         m_grant;
  bit         m_full;
  logic [W-1:0] m_data;
  int         m_owner;
  int         m_ptr;
  int         m_wait;
  bit         m_drop;

  buffer_reg_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_owner  (out_owner),
    .out_ready  (out_ready),
    .drop_pulse (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant = -1;
    m_full  = 0;
    m_data  = '0;
    m_owner = 0;
    m_ptr   = 0;
    m_wait  = 0;
    m_drop  = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit drop_n;
    drop_n = 0;
    if (m_full) begin
      if (out_ready) begin
        m_full = 0;
      end else begin
        m_wait++;
`ifdef BUFREG_ARB_TIMEOUT_EN
        if (m_wait == TO) begin
          m_full = 0;
          drop_n = 1;
        end
`endif
      end
    end else if (m_grant >= 0) begin
      if (req_valid[m_grant]) begin
        m_full  = 1;
        m_data  = req_data[m_grant*W +: W];
        m_owner = m_grant;
        m_ptr   = (m_grant + 1) % N;
        m_wait  = 0;
      end
      m_grant = -1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req_valid[j]) begin
          m_grant = j;
          break;
        end
      end
    end
    m_drop = drop_n;
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_rdy;
    exp_rdy = (m_grant >= 0) ? N'(1 << m_grant) : '0;
    check("req_ready", req_ready, exp_rdy);
    check("out_valid", out_valid, m_full);
    check("out_data", out_data, m_data);
    check("out_owner", out_owner, m_owner);
    check("drop_pulse", drop_pulse, m_drop);
  endtask

  // One clock: model advances, DUT is sampled on the following falling edge
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_outputs();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int owners[$];
    int times[$];
    int drop_at;

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    model_reset();

    // 1. reset values, then asynchronous reset while FULL
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_owner", out_owner, 0);
    check("rst_drop", drop_pulse, 0);
    reset = 1'b0;
    req_valid = 4'b0001;
    req_data  = {4'h0, 4'h0, 4'h0, 4'b0110};
    cycle();
    cycle();
    check("async_pre_valid", out_valid, 1);
    check("async_pre_data", out_data, 4'b0110);
    #2 reset = 1'b1;
    #1;
    check("async_valid_clr", out_valid, 0);
    check("async_data_clr", out_data, 0);
    req_valid = '0;
    @(negedge clk);
    model_reset();
    reset = 1'b0;

    // 2. single request from requester 2, then pointer must favour requester 3
    req_valid = 4'b0100;
    req_data  = {4'h0, 4'b0101, 4'h0, 4'h0};
    out_ready = 1'b1;
    cycle();
    check("single_grant", req_ready, 4'b0100);
    cycle();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 4'b0101);
    check("single_owner", out_owner, 2);
    check("single_ready_low", req_ready, 0);
    req_valid = 4'b1111;
    cycle();
    cycle();
    check("single_next_grant", req_ready, 4'b1000);

    // 3. round robin with all requesters active and a free consumer
    do_reset();
    req_valid = 4'b1111;
    req_data  = {4'hD, 4'hC, 4'hB, 4'hA};
    out_ready = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      cycle();
      if (out_valid) begin
        owners.push_back(int'(out_owner));
        times.push_back(c);
      end
    end
    check("rr_count", owners.size(), 5);
    for (int k = 0; k < 5 && k < owners.size(); k++) begin
      check("rr_owner", owners[k], k % N);
      if (k > 0) check("rr_spacing", times[k] - times[k-1], 3);
    end

    // 4. backpressure holds the word and blocks grants
    do_reset();
    req_valid = 4'b1111;
    req_data  = {4'h3, 4'h2, 4'h1, 4'b1010};
    cycle();
    cycle();
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 4'b1010);
      check("bp_ready", req_ready, 0);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_release", out_valid, 0);
    cycle();
    check("bp_next_grant", req_ready, 4'b0010);

    // 5. withdrawal during LOAD leaves the pointer alone
    do_reset();
    req_valid = 4'b0010;
    req_data  = {4'h4, 4'h3, 4'h2, 4'h1};
    out_ready = 1'b1;
    cycle();
    check("wd_grant", req_ready, 4'b0010);
    req_valid = 4'b0000;
    cycle();
    check("wd_no_capture", out_valid, 0);
    check("wd_ready_low", req_ready, 0);
    req_valid = 4'b1111;
    cycle();
    check("wd_ptr_kept", req_ready, 4'b0001);

    // Long stall: waits indefinitely without the feature, drops with it
    do_reset();
    req_valid = 4'b0001;
    req_data  = {4'h0, 4'h0, 4'h0, 4'b0011};
    cycle();
    cycle();
    req_valid = 4'b0010;
    drop_at = -1;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (drop_pulse && drop_at < 0) drop_at = c;
    end
`ifdef BUFREG_ARB_TIMEOUT_EN
    // 6. timeout drop after TO stalled cycles, then the next grant proceeds
    check("to_drop_cycle", drop_at, TO);
    do_reset();
    req_valid = 4'b0001;
    cycle();
    cycle();
    req_valid = 4'b0010;
    for (int c = 1; c < TO; c++) cycle();
    cycle();
    check("to_drop_pulse", drop_pulse, 1);
    check("to_drop_valid", out_valid, 0);
    cycle();
    check("to_pulse_once", drop_pulse, 0);
    check("to_next_grant", req_ready, 4'b0010);
    do_reset();
    req_valid = 4'b0001;
    cycle();
    cycle();
    req_valid = 4'b0000;
    for (int c = 1; c < TO; c++) cycle();
    out_ready = 1'b1;
    cycle();
    check("to_accept_valid", out_valid, 0);
    check("to_accept_nodrop", drop_pulse, 0);
`else
    check("stall_no_drop", drop_at, -1);
    check("stall_still_valid", out_valid, 1);
`endif

    // Randomized traffic with sticky requests and bursty consumer
    do_reset();
    req_data = $urandom;
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 299) do_reset();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) req_valid[i] = ~req_valid[i];
      end
      req_data = $urandom;
      if ((c / 40) % 2 == 0) out_ready = ($urandom_range(3) != 0);
      else out_ready = ($urandom_range(7) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_reg_arbiter.md
# buffer_reg_arbiter

Round-robin arbiter and sequencer that shares one DATA_W-bit buffer register between NUM_REQ requesters. It sits in front of the team's buffer register datapath. It picks one requester, handshakes its data into the buffer, and holds the data with an owner tag until a downstream consumer accepts it. Only one word is in flight at a time, and the controller guarantees the buffer is never overwritten before it is consumed.

## Interface
- NUM_REQ, 4: number of requesters; must be at least 2.
- DATA_W, 4: width of the buffer register and of each requester's data.
- TIMEOUT, 16: cycles in FULL before the word is dropped. Used only when BUFREG_ARB_TIMEOUT_EN is defined; must be at least 1.

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; bit i belongs to requester i.
- req_data  in  NUM_REQ*DATA_W  packed data; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  registered one-hot grant strobe, high only in LOAD.
- out_valid  out  1  buffer holds a word for the consumer.
- out_data  out  DATA_W  buffer register contents.
- out_owner  out  $clog2(NUM_REQ)  index of the requester that wrote the word.
- out_ready  in  1  consumer accepts the word.
- drop_pulse  out  1  one-cycle pulse when a word is discarded by timeout; constant 0 without the macro.

## Operation
- Reset values:
  - State is IDLE and rr_ptr is 0.
  - req_ready, out_valid, out_data, out_owner and drop_pulse are all 0.
- The FSM has three states: IDLE, LOAD and FULL.
- IDLE (buffer empty):
  - Scan req_valid starting at rr_ptr, upward modulo NUM_REQ. The first set bit wins.
  - On a winner, register grant_idx = winner and go to LOAD.
  - With no request, stay in IDLE.
- LOAD:
  - req_ready[grant_idx] = 1; all other bits are 0.
  - If req_valid[grant_idx] is still 1, capture that requester's data:
    - out_data <= req_data[grant_idx], out_owner <= grant_idx, out_valid <= 1.
    - rr_ptr <= (grant_idx+1) mod NUM_REQ.
    - Go to FULL.
  - If the requester withdrew (req_valid[grant_idx] is 0), capture nothing, leave rr_ptr unchanged and return to IDLE.
- FULL:
  - out_valid = 1. out_data and out_owner are held stable.
  - When out_ready is 1, clear out_valid and go to IDLE.
  - out_data keeps its last value after the clear.
  - No req_ready is asserted while in FULL.
- A requester is transferred on the edge that ends its LOAD cycle, when req_valid and req_ready are both 1.
- Arbitration is fair: any requester that holds req_valid continuously is granted within NUM_REQ transfers.
- Reset asserted mid-operation (any state) immediately forces the reset values. A word in flight is lost and is not reported by drop_pulse.

## Timing
- Grant latency: req_valid sampled in IDLE at edge k gives req_ready high during the cycle after edge k.
- Capture occurs at edge k+1; out_valid is high after edge k+1.
- Minimum cycle per transfer is 3 clocks (IDLE, LOAD, FULL), reached when out_ready is held at 1.
- out_ready is sampled only in FULL and ignored in other states.
- All outputs are registered, with no combinational paths from input to output.

## Configuration
- Macro BUFREG_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to FULL and increments each FULL cycle in which out_ready is 0.
  - When the counter reaches TIMEOUT with out_ready still 0, then on the next edge: out_valid <= 0, drop_pulse <= 1 for one cycle, and the state returns to IDLE.
  - If out_ready is 1 in the same cycle, the acceptance wins and there is no drop.
- Not defined: FULL waits indefinitely, drop_pulse is tied to 0, and the TIMEOUT parameter is unused.

## Test plan
1. Reset: hold reset for 2 cycles → all outputs 0. Reach FULL with data 0110, then assert reset between edges → out_valid falls to 0 without waiting for a clock edge.
2. Single request: req_valid = 0100, requester 2 data = 0101, out_ready = 1 → req_ready = 0100 for one cycle, then out_valid = 1 with out_data = 0101 and out_owner = 2. rr_ptr is then 3.
3. Round robin: req_valid = 1111 held, distinct data per requester, out_ready = 1 → owners 0, 1, 2, 3, 0 in order, with one transfer every 3 cycles.
4. Backpressure: capture 1010, hold out_ready = 0 for 5 cycles while req_valid = 1111 → out_valid stays 1, out_data stays 1010 and req_ready stays 0000. Raise out_ready → next grant goes to owner+1.
5. Withdrawal: requester 1 is granted, then drops req_valid during LOAD → no capture, out_valid stays 0, FSM returns to IDLE, and rr_ptr is unchanged.
6. Timeout (macro defined, TIMEOUT = 8): capture 0011, hold out_ready = 0 → after 8 FULL cycles, drop_pulse is 1 for one cycle, out_valid goes to 0 and the next grant proceeds. Repeat with out_ready = 1 on the 8th cycle → accepted, no drop_pulse.
